load_store_unit: RTL and testbench

Sits between the execute stage and the word-addressed data memory (`register_count` words of `data_length` bits). It handles the memory side of RV32I loads and stores:
- byte/halfword/word loads, with sign or zero extension;
- word stores as a single write;
- sub-word stores as a read-modify-write sequence;
- misaligned and out-of-range accesses, reported as errors with no memory access.

The memory read is combinational. The memory write happens on the rising edge of clk.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/load_store_unit_if.sv | 23 ++
 rtl/lsu_lane_align.sv | 48 ++++
 rtl/load_store_unit.sv | 138 +++++++++++++
 tb/tb_load_store_unit.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state
// encoding, the captured-request payload and the access legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_e;

  // Only the request fields still needed after acceptance are kept.
  typedef struct packed {
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic [15:0] wdata_lo;
  } req_t;

  // Illegal funct3 for the direction, or a misaligned half/word access.
  function automatic logic access_err(input logic store, input logic [2:0] funct3,
                                      input logic [1:0] off);
    logic legal;
    logic misal;
    legal = store ? (funct3 inside {F3_B, F3_H, F3_W})
                  : (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misal = ((funct3[1:0] == 2'b01) && off[0]) || ((funct3 == F3_W) && (off != 2'b00));
    return !legal || misal;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake between the execute stage (master) and the
// load/store unit (slave).
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_data;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_data
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_data
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store unit.
//   word_i      : word read from memory
//   wdata_i     : low 16 bits of store data
//   off_i       : byte offset within the word
//   funct3_i    : access size / extension
//   ld_word_c_o : extracted and extended load result
//   st_word_c_o : word_i with the addressed byte/half replaced by store data
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [15:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] ld_word_c_o,
  output logic [31:0] st_word_c_o
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Load extract and extend.
  always_comb begin
    byte_c = word_i[{off_i, 3'b000} +: 8];
    half_c = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    ld_word_c_o = {{24{byte_c[7]}}, byte_c};
      F3_BU:   ld_word_c_o = {24'b0, byte_c};
      F3_H:    ld_word_c_o = {{16{half_c[15]}}, half_c};
      F3_HU:   ld_word_c_o = {16'b0, half_c};
      default: ld_word_c_o = word_i;
    endcase
  end

  // Store merge for the read-modify-write path.
  always_comb begin
    st_word_c_o = word_i;
    case (funct3_i)
      F3_B: st_word_c_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_H: begin
        if (off_i[1]) st_word_c_o[31:16] = wdata_i;
        else          st_word_c_o[15:0]  = wdata_i;
      end
      default: st_word_c_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-addressed data memory.
//   clk, rst   : clock, asynchronous active-low reset
//   lsu        : request/response handshake (slave side)
//   mem_addr   : word index, 0 when no memory access
//   mem_w_data : write word, 0 when no write
//   mem_r_ctrl : read enable (LOAD, RMW_RD)
//   mem_w_ctrl : write enable (WRITE)
//   mem_r_data : combinational read word
module load_store_unit
  import lsu_pkg::*;
#(
  parameter  int unsigned register_count = 32,
  parameter  int unsigned data_length    = 32,
  localparam int unsigned ADDR_W         = $clog2(register_count)
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  lsu,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_w_data,
  output logic              mem_r_ctrl,
  output logic              mem_w_ctrl,
  input  logic [31:0]       mem_r_data
);

  localparam int unsigned MEM_BYTES = 4 * register_count;

  if (data_length != 32) begin : g_width_check
    $error("load_store_unit: data_length must be 32");
  end

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              mem_r_q, mem_r_d;
  logic              mem_w_q, mem_w_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_w_data_q, mem_w_data_d;
  logic              accept_c;
  logic              err_c;
  logic [31:0]       ld_word_c;
  logic [31:0]       st_word_c;

  lsu_lane_align u_align (
    .word_i      (mem_r_data),
    .wdata_i     (req_q.wdata_lo),
    .off_i       (req_q.off),
    .funct3_i    (req_q.funct3),
    .ld_word_c_o (ld_word_c),
    .st_word_c_o (st_word_c)
  );

  // Next state and next registered outputs; outputs are decoded from state_d
  // so each one is a flop that is valid during the state it belongs to.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    accept_c = lsu.req_valid && req_ready_q;
    err_c    = access_err(lsu.req_store, lsu.req_funct3, lsu.req_addr[1:0]) ||
               (lsu.req_addr >= MEM_BYTES);

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          req_d = '{funct3: lsu.req_funct3, off: lsu.req_addr[1:0],
                    wdata_lo: lsu.req_wdata[15:0]};
          if (err_c)                        state_d = RESP;
          else if (!lsu.req_store)          state_d = LOAD;
          else if (lsu.req_funct3 == F3_W)  state_d = WRITE;
          else                              state_d = RMW_RD;
        end
      end
      LOAD:    state_d = RESP;
      RMW_RD:  state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    mem_r_d = (state_d == LOAD) || (state_d == RMW_RD);
    mem_w_d = (state_d == WRITE);

    // The word index comes from the bus on acceptance and is then held.
    mem_addr_d = '0;
    if (mem_r_d || mem_w_d)
      mem_addr_d = (state_q == IDLE) ? lsu.req_addr[ADDR_W+1:2] : mem_addr_q;

    // SW writes the bus data directly; SB/SH write the merged read word.
    mem_w_data_d = '0;
    if (mem_w_d)
      mem_w_data_d = (state_q == RMW_RD) ? st_word_c : lsu.req_wdata;

    rsp_valid_d = (state_d == RESP);
    rsp_err_d   = (state_q == IDLE) && accept_c && err_c;
    rsp_data_d  = (state_q == LOAD) ? ld_word_c : '0;
    req_ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
      mem_r_q      <= 1'b0;
      mem_w_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_w_data_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_data_q   <= rsp_data_d;
      mem_r_q      <= mem_r_d;
      mem_w_q      <= mem_w_d;
      mem_addr_q   <= mem_addr_d;
      mem_w_data_q <= mem_w_data_d;
    end
  end

  assign lsu.req_ready = req_ready_q;
  assign lsu.rsp_valid = rsp_valid_q;
  assign lsu.rsp_err   = rsp_err_q;
  assign lsu.rsp_data  = rsp_data_q;
  assign mem_r_ctrl    = mem_r_q;
  assign mem_w_ctrl    = mem_w_q;
  assign mem_addr      = mem_addr_q;
  assign mem_w_data    = mem_w_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a scoreboard of expected responses
// and a behavioural 32-word memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [4:0]  mem_addr;
  logic [31:0] mem_w_data;
  logic        mem_r_ctrl;
  logic        mem_w_ctrl;
  logic [31:0] mem_r_data;
  logic [31:0] mem [32];

  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        sb_q[$];
  int unsigned rd_cnt = 0, wr_cnt = 0, rsp_cnt = 0;
  int unsigned last_rd_cyc = 0, last_wr_cyc = 0;
  logic [4:0]  last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  load_store_unit_if lsu_if ();

  load_store_unit #(.register_count(32), .data_length(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .lsu        (lsu_if),
    .mem_addr   (mem_addr),
    .mem_w_data (mem_w_data),
    .mem_r_ctrl (mem_r_ctrl),
    .mem_w_ctrl (mem_w_ctrl),
    .mem_r_data (mem_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_r_data = mem[mem_addr];
  always @(posedge clk) if (mem_w_ctrl) mem[mem_addr] <= mem_w_data;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: memory activity log plus scoreboard pop on each response.
  always @(negedge clk) begin
    if (mem_r_ctrl) begin
      rd_cnt      <= rd_cnt + 1;
      last_rd_cyc <= cyc;
    end
    if (mem_w_ctrl) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_cyc  <= cyc;
      last_wr_addr <= mem_addr;
      last_wr_data <= mem_w_data;
    end
    if (!mem_r_ctrl && !mem_w_ctrl) chk("mem_idle_zero", mem_w_data | 32'(mem_addr), 32'h0);
    if (!lsu_if.rsp_valid) chk("rsp_data_idle", lsu_if.rsp_data, 32'h0);
    if (lsu_if.rsp_valid) begin
      exp_t e;
      rsp_cnt <= rsp_cnt + 1;
      total++;
      assert (sb_q.size() != 0) else begin
        bad++;
        $error("FAIL rsp_extra: observed=unexpected rsp_valid at cycle %0d expected=none", cyc);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("rsp_err", 32'(lsu_if.rsp_err), 32'(e.err));
        chk("rsp_data", lsu_if.rsp_data, e.data);
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  // Issue one request at a negedge while idle; t returns the acceptance cycle.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic e, input logic [31:0] d,
                       input int unsigned lat, output int unsigned t);
    int n = 0;
    while (lsu_if.req_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(lsu_if.req_ready), 32'h1);
    t = cyc;
    lsu_if.req_store  = st;
    lsu_if.req_funct3 = f3;
    lsu_if.req_addr   = a;
    lsu_if.req_wdata  = wd;
    lsu_if.req_valid  = 1'b1;
    sb_q.push_back('{err: e, data: d, cyc: t + lat});
    @(posedge clk);
    #1;
    lsu_if.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(sb_q.size()), 32'h0);
    @(negedge clk);
  endtask

  initial begin
    int unsigned t;
    int unsigned rd0, wr0, rsp0;

    rst = 1'b0;
    lsu_if.req_valid  = 1'b0;
    lsu_if.req_store  = 1'b0;
    lsu_if.req_funct3 = 3'b000;
    lsu_if.req_addr   = 32'h0;
    lsu_if.req_wdata  = 32'h0;
    for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
    mem[3]  <= 32'h8081_F2F3;
    mem[31] <= 32'h1234_5678;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(lsu_if.req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(lsu_if.rsp_valid), 32'h0);
    chk("reset_ctrl", 32'({mem_r_ctrl, mem_w_ctrl}), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(lsu_if.req_ready), 32'h1);

    // Sub-word loads with sign/zero extension.
    issue(1'b0, F3_B,  32'h0E, 32'h0, 1'b0, 32'hFFFF_FF81, 2, t); drain();
    issue(1'b0, F3_BU, 32'h0E, 32'h0, 1'b0, 32'h0000_0081, 2, t); drain();
    issue(1'b0, F3_H,  32'h0C, 32'h0, 1'b0, 32'hFFFF_F2F3, 2, t); drain();
    issue(1'b0, F3_HU, 32'h0E, 32'h0, 1'b0, 32'h0000_8081, 2, t); drain();
    issue(1'b0, F3_BU, 32'h0D, 32'h0, 1'b0, 32'h0000_00F2, 2, t); drain();
    issue(1'b0, F3_W,  32'h7C, 32'h0, 1'b0, 32'h1234_5678, 2, t); drain();

    // Word store: single write at T+1, response at T+2.
    wr0 = wr_cnt;
    issue(1'b1, F3_W, 32'h08, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, t); drain();
    chk("sw_write_count", wr_cnt - wr0, 32'h1);
    chk("sw_write_cycle", last_wr_cyc, t + 1);
    chk("sw_write_addr", 32'(last_wr_addr), 32'h2);
    chk("sw_write_data", last_wr_data, 32'hDEAD_BEEF);
    issue(1'b0, F3_W, 32'h08, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, t); drain();

    // Half store via read-modify-write.
    issue(1'b1, F3_H, 32'h0E, 32'h0000_ABCD, 1'b0, 32'h0, 3, t); drain();
    chk("sh_read_cycle", last_rd_cyc, t + 1);
    chk("sh_write_cycle", last_wr_cyc, t + 2);
    chk("sh_write_data", last_wr_data, 32'hABCD_F2F3);
    chk("sh_mem", mem[3], 32'hABCD_F2F3);

    // Byte store via read-modify-write.
    issue(1'b1, F3_B, 32'h0D, 32'hFFFF_FF55, 1'b0, 32'h0, 3, t); drain();
    chk("sb_write_cycle", last_wr_cyc, t + 2);
    chk("sb_mem", mem[3], 32'hABCD_55F3);

    // Errors: response at T+1 with no memory activity.
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    issue(1'b0, F3_W,   32'h0D, 32'h0, 1'b1, 32'h0, 1, t); drain();
    issue(1'b0, F3_H,   32'h03, 32'h0, 1'b1, 32'h0, 1, t); drain();
    issue(1'b0, 3'b011, 32'h00, 32'h0, 1'b1, 32'h0, 1, t); drain();
    issue(1'b0, F3_W,   32'h80, 32'h0, 1'b1, 32'h0, 1, t); drain();
    issue(1'b1, F3_H,   32'h01, 32'h0, 1'b1, 32'h0, 1, t); drain();
    issue(1'b1, F3_BU,  32'h00, 32'h0, 1'b1, 32'h0, 1, t); drain();
    chk("err_no_read", rd_cnt - rd0, 32'h0);
    chk("err_no_write", wr_cnt - wr0, 32'h0);
    chk("err_mem_intact", mem[0], 32'h0);

    // Back-to-back loads with req_valid held high.
    rsp0 = rsp_cnt;
    t = cyc;
    lsu_if.req_store  = 1'b0;
    lsu_if.req_funct3 = F3_W;
    lsu_if.req_addr   = 32'h08;
    lsu_if.req_valid  = 1'b1;
    for (int k = 0; k < 3; k++)
      sb_q.push_back('{err: 1'b0, data: 32'hDEAD_BEEF, cyc: t + 2 + 3 * k});
    for (int i = 0; i < 9; i++) begin
      chk("b2b_ready", 32'(lsu_if.req_ready), (i % 3 == 0) ? 32'h1 : 32'h0);
      @(posedge clk);
      #1;
      if (i == 6) lsu_if.req_valid = 1'b0;
      @(negedge clk);
    end
    drain();
    chk("b2b_rsp_count", rsp_cnt - rsp0, 32'h3);

    // Reset asserted during the WRITE of an SB: write must be suppressed.
    issue(1'b1, F3_B, 32'h0C, 32'h0000_0011, 1'b0, 32'h0, 3, t);
    @(negedge clk);
    @(negedge clk);
    chk("rst_write_active", 32'(mem_w_ctrl), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_write_drop", 32'(mem_w_ctrl), 32'h0);
    chk("rst_ready_low", 32'(lsu_if.req_ready), 32'h0);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready_after", 32'(lsu_if.req_ready), 32'h1);
    chk("rst_mem_unchanged", mem[3], 32'hABCD_55F3);

    // Unit still works after the mid-transaction reset.
    issue(1'b0, F3_HU, 32'h0E, 32'h0, 1'b0, 32'h0000_ABCD, 2, t); drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
